watch_time_controller: RTL and testbench

- Mode/sequencing controller for the watch timekeeping chain: seconds (mod-60), minutes (mod-60) and hours (12-hour, mod-13-style) digit counters.
- Turns the 1 Hz tick and the user buttons into one-cycle increment/clear strobes for each counter, and runs the RUN / PAUSED / SET_HOUR / SET_MIN mode machine.
- Sits between the button/tick front end and the counter datapath.
- Provides blink enables to the display mux.

---
 rtl/watch_pkg.sv | 13 +
 rtl/watch_time_controller_btn_edge_detect.sv | 11 +
 rtl/watch_time_controller.sv | 88 ++++++++
 tb/tb_watch_time_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// watch_pkg: mode encodings shared by the watch controller, display mux and counters.
package watch_pkg;
    localparam int MODE_W = 2;
    typedef enum logic [MODE_W-1:0] {
        RUN      = 2'd0,
        PAUSED   = 2'd1,
        SET_HOUR = 2'd2,
        SET_MIN  = 2'd3
    } state_e;
    function automatic logic is_set(state_e s);
        return s == SET_HOUR || s == SET_MIN;
    endfunction
endpackage

// File: rtl/watch_time_controller_btn_edge_detect.sv
// btn_edge_detect: registers a debounced button and emits a one-cycle rising-edge pulse.
module btn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);
    logic btn_q;
    always_ff @(posedge clk) btn_q <= reset ? 1'b0 : btn_i;
    assign rise_o = btn_i & ~btn_q;
endmodule

// File: rtl/watch_time_controller.sv
// watch_time_controller: RUN/PAUSED/SET mode machine turning the 1 Hz tick and buttons
// into registered increment/clear strobes and blink enables.
module watch_time_controller
    import watch_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 10,
    parameter int TO_W          = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              start_resume,
    input  logic              stop,
    input  logic              mode_btn,
    input  logic              adj_btn,
    input  logic              sec_at_max,
    input  logic              min_at_max,
    output logic              inc_sec,
    output logic              inc_min,
    output logic              inc_hour,
    output logic              clr_sec,
    output logic              blink_hour,
    output logic              blink_min,
    output logic [MODE_W-1:0] mode
);
    state_e          state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            phase_q, phase_d;
    logic            mode_rise, adj_rise, stay_set;
    logic            inc_sec_d, inc_min_d, inc_hour_d, clr_sec_d;

    btn_edge_detect u_mode_edge (.clk(clk), .reset(reset), .btn_i(mode_btn), .rise_o(mode_rise));
    btn_edge_detect u_adj_edge  (.clk(clk), .reset(reset), .btn_i(adj_btn),  .rise_o(adj_rise));

    // A mode edge pre-empts everything else, so a simultaneous adj edge is dropped.
    always_comb begin
        state_d    = state_q;
        inc_sec_d  = 1'b0;
        inc_min_d  = 1'b0;
        inc_hour_d = 1'b0;
        clr_sec_d  = 1'b0;
        if (mode_rise) begin
            state_d   = state_q == SET_HOUR ? SET_MIN : state_q == SET_MIN ? RUN : SET_HOUR;
            clr_sec_d = state_q == SET_MIN;
        end else if (state_q == RUN) begin
            state_d    = stop ? PAUSED : RUN;
            inc_sec_d  = tick_1hz & ~stop;
            inc_min_d  = inc_sec_d & sec_at_max;
            inc_hour_d = inc_min_d & min_at_max;
        end else if (state_q == PAUSED) begin
            state_d = start_resume & ~stop ? RUN : PAUSED;
        end else if (adj_rise) begin
            inc_hour_d = state_q == SET_HOUR;
            inc_min_d  = state_q == SET_MIN;
        end else if (tick_1hz && to_q == TO_W'(TIMEOUT_TICKS - 1)) begin
            state_d = RUN;
        end
        stay_set = is_set(state_q) && is_set(state_d);
        to_d     = stay_set && !mode_rise && !adj_rise ? to_q + TO_W'(tick_1hz) : '0;
        phase_d  = stay_set && !adj_rise && (phase_q ^ tick_1hz);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            to_q       <= '0;
            phase_q    <= 1'b0;
            inc_sec    <= 1'b0;
            inc_min    <= 1'b0;
            inc_hour   <= 1'b0;
            clr_sec    <= 1'b0;
            blink_hour <= 1'b0;
            blink_min  <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_q       <= to_d;
            phase_q    <= phase_d;
            inc_sec    <= inc_sec_d;
            inc_min    <= inc_min_d;
            inc_hour   <= inc_hour_d;
            clr_sec    <= clr_sec_d;
            blink_hour <= phase_d & (state_d == SET_HOUR);
            blink_min  <= phase_d & (state_d == SET_MIN);
        end
    end

    assign mode = state_q;
endmodule

// File: tb/tb_watch_time_controller.sv
// tb_watch_time_controller: directed literal checks plus randomized traffic against a behavioural model.
module tb_watch_time_controller;
    localparam int TIMEOUT_TICKS = 10;

    logic       clk, reset, tick_1hz, start_resume, stop, mode_btn, adj_btn, sec_at_max, min_at_max;
    logic       inc_sec, inc_min, inc_hour, clr_sec, blink_hour, blink_min;
    logic [1:0] mode;

    watch_time_controller #(.TIMEOUT_TICKS(TIMEOUT_TICKS), .TO_W(4)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .start_resume(start_resume), .stop(stop),
        .mode_btn(mode_btn), .adj_btn(adj_btn), .sec_at_max(sec_at_max), .min_at_max(min_at_max),
        .inc_sec(inc_sec), .inc_min(inc_min), .inc_hour(inc_hour), .clr_sec(clr_sec),
        .blink_hour(blink_hour), .blink_min(blink_min), .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int n_is = 0, n_im = 0, n_ih = 0, n_clr = 0;
    bit check_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode as an integer 0..3 stepping RUN/PAUSED -> 2 -> 3 -> 0, timeout as a tick count.
    int         m_mode = 0, m_cnt = 0;
    bit         m_ph = 0, m_mb = 0, m_ab = 0;
    logic [2:0] exp_inc;
    logic       exp_clr, exp_bh, exp_bm;
    logic [1:0] exp_mode;

    always @(posedge clk) begin
        bit         me, ae, was_set, clr;
        logic [2:0] inc;
        inc = 3'b000;
        clr = 0;
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_ph = 0; m_mb = 0; m_ab = 0;
        end else begin
            me = mode_btn && !m_mb;
            ae = adj_btn && !m_ab;
            m_mb = mode_btn;
            m_ab = adj_btn;
            was_set = m_mode >= 2;
            if (me) begin
                clr = m_mode == 3;
                m_mode = m_mode < 2 ? 2 : (m_mode + 1) % 4;
                m_cnt = 0;
                m_ph = (was_set && m_mode == 3 && !ae) ? (m_ph ^ tick_1hz) : 1'b0;
            end else if (m_mode == 0) begin
                if (stop) m_mode = 1;
                else if (tick_1hz) inc = {sec_at_max && min_at_max, sec_at_max, 1'b1};
            end else if (m_mode == 1) begin
                if (start_resume && !stop) m_mode = 0;
            end else if (ae) begin
                inc = m_mode == 2 ? 3'b100 : 3'b010;
                m_cnt = 0;
                m_ph = 0;
            end else if (tick_1hz) begin
                m_cnt++;
                if (m_cnt >= TIMEOUT_TICKS) begin
                    m_mode = 0; m_cnt = 0; m_ph = 0;
                end else m_ph = !m_ph;
            end
        end
        exp_inc  <= inc;
        exp_clr  <= clr;
        exp_mode <= 2'(m_mode);
        exp_bh   <= m_ph && m_mode == 2;
        exp_bm   <= m_ph && m_mode == 3;
    end

    always @(negedge clk) if (check_en) begin
        chk("m_mode", 32'(mode), 32'(exp_mode));
        chk("m_inc", 32'({inc_hour, inc_min, inc_sec}), 32'(exp_inc));
        chk("m_clr", 32'(clr_sec), 32'(exp_clr));
        chk("m_blink", 32'({blink_hour, blink_min}), 32'({exp_bh, exp_bm}));
    end

    task automatic drive(input logic t, st, sp, mb, ab, sm, mm);
        tick_1hz = t; start_resume = st; stop = sp; mode_btn = mb; adj_btn = ab;
        sec_at_max = sm; min_at_max = mm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n_is += 32'(inc_sec); n_im += 32'(inc_min); n_ih += 32'(inc_hour); n_clr += 32'(clr_sec);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check_en = 1;
        reset = 1'b0;
        step();
        chk("reset_mode", 32'(mode), 0);
        chk("reset_outs", 32'({inc_hour, inc_min, inc_sec, clr_sec, blink_hour, blink_min}), 0);

        n_is = 0; n_im = 0; n_ih = 0;
        repeat (3) begin
            drive(1, 0, 0, 0, 0, 0, 0); step();
            chk("tick_latency", 32'(inc_sec), 1);
            idle();
            chk("tick_single", 32'(inc_sec), 0);
        end
        chk("three_secs", 32'(n_is), 3);
        chk("no_carry", 32'(n_im + n_ih), 0);

        drive(1, 0, 0, 0, 0, 1, 1); step();
        chk("carry_hour", 32'({inc_hour, inc_min, inc_sec}), 32'b111);
        idle();
        drive(1, 0, 0, 0, 0, 1, 0); step();
        chk("carry_min", 32'({inc_hour, inc_min, inc_sec}), 32'b011);
        idle();

        drive(1, 0, 1, 0, 0, 1, 1); step();
        chk("stop_mode", 32'(mode), 1);
        chk("stop_no_strobe", 32'({inc_hour, inc_min, inc_sec}), 0);
        drive(1, 0, 0, 0, 0, 0, 0); step();
        chk("paused_tick", 32'(inc_sec), 0);
        drive(0, 1, 1, 0, 0, 0, 0); step();
        chk("start_and_stop", 32'(mode), 1);
        drive(0, 1, 0, 0, 0, 0, 0); step();
        chk("resume_mode", 32'(mode), 0);
        drive(1, 0, 0, 0, 0, 0, 0); step();
        chk("resume_tick", 32'(inc_sec), 1);
        idle();

        n_im = 0; n_ih = 0; n_clr = 0;
        drive(0, 0, 0, 1, 0, 0, 0); step();
        chk("set_hour_mode", 32'(mode), 2);
        idle();
        repeat (2) begin
            drive(0, 0, 0, 0, 1, 0, 0); step();
            idle();
        end
        chk("adj_hours", 32'(n_ih), 2);
        chk("adj_hour_no_min", 32'(n_im), 0);
        drive(0, 0, 0, 1, 0, 0, 0); step();
        chk("set_min_mode", 32'(mode), 3);
        idle();
        drive(0, 0, 0, 0, 1, 1, 1);
        repeat (20) step();
        idle();
        chk("adj_held_once", 32'(n_im), 1);
        chk("adj_min_no_carry", 32'(n_ih), 2);
        drive(0, 0, 0, 1, 0, 0, 0); step();
        chk("exit_mode", 32'(mode), 0);
        chk("exit_clr", 32'(clr_sec), 1);
        idle();
        chk("clr_single", 32'(clr_sec), 0);

        drive(0, 0, 0, 1, 0, 0, 0); step();
        idle();
        n_clr = 0;
        for (int k = 1; k <= TIMEOUT_TICKS; k++) begin
            drive(1, 0, 0, 0, 0, 0, 0); step();
            if (k < TIMEOUT_TICKS) begin
                chk("to_blink", 32'(blink_hour), 32'(k % 2));
                chk("to_hold_mode", 32'(mode), 2);
            end else begin
                chk("to_mode", 32'(mode), 0);
                chk("to_blink_off", 32'(blink_hour), 0);
            end
            idle();
        end
        chk("to_no_clr", 32'(n_clr), 0);

        drive(0, 0, 0, 1, 0, 0, 0); step();
        idle();
        drive(0, 0, 0, 1, 0, 0, 0); step();
        idle();
        chk("pre_reset_mode", 32'(mode), 3);
        reset = 1'b1;
        drive(1, 1, 1, 1, 1, 1, 1); step();
        chk("rst_mode", 32'(mode), 0);
        chk("rst_outs", 32'({inc_hour, inc_min, inc_sec, clr_sec, blink_hour, blink_min}), 0);
        reset = 1'b0;
        idle();
        chk("post_rst_mode", 32'(mode), 0);

        n_ih = 0;
        drive(0, 0, 0, 1, 0, 0, 0); step();
        idle();
        drive(0, 0, 0, 1, 1, 0, 0); step();
        chk("simul_mode", 32'(mode), 3);
        chk("simul_no_hour", 32'(n_ih), 0);
        idle();
        drive(0, 0, 0, 1, 0, 0, 0); step();
        idle();

        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(99) == 0;
            drive($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
                  $urandom_range(5) == 0, $urandom_range(3) == 0, 1'($urandom), 1'($urandom));
            step();
        end
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(1) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
                  $urandom_range(59) == 0, $urandom_range(39) == 0, 1'($urandom), 1'($urandom));
            step();
        end
        idle();
        @(negedge clk);
        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
